dpram_rd_seq: RTL and testbench
===============================

Name: dpram_rd_seq

Overview:
- Port-A read sequencer for the feature-map DPRAM (16-byte words, 1-cycle synchronous read, addr_valid forces zero data).
- Walks a C x H x W feature map in 3-row convolution-window order and emits one 16-byte read per beat.
- Rows above and below the map are padding beats: it drives addr_valid=0 on those beats.
- Sits between the layer controller (start/done) and the systolic-array input buffer (rd_ready/data_valid).

Parameters:
ADDR_WIDTH, 19, DPRAM byte-address width
DIM_WIDTH, 9, width/height field width (max 511)
CH_WIDTH, 8, channel-count field width
KERNEL, 3, kernel rows per output row; top/bottom padding = (KERNEL-1)/2
WORD_BYTES, 16, bytes per DPRAM access; cfg_width must be a multiple of it

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
start  in  1  one-cycle pulse; accepted only in IDLE
cfg_base  in  ADDR_WIDTH  byte address of channel 0, row 0, col 0
cfg_width  in  DIM_WIDTH  map width W in bytes
cfg_height  in  DIM_WIDTH  map height H
cfg_channels  in  CH_WIDTH  channel count C
cfg_plane  in  ADDR_WIDTH  channel stride, normally W*H
rd_ready  in  1  downstream can take one word next cycle
we_a  out  1  DPRAM port-A write enable; constant 0
addr_a  out  ADDR_WIDTH  DPRAM port-A address
addr_valid  out  1  DPRAM port-A addr_valid; 0 on padding beats
data_valid  out  1  DPRAM dout_a is valid this cycle
data_krow  out  2  kernel-row index of the word in dout_a
data_last  out  1  with data_valid: final word of the job
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end
cfg_err  out  1  qualifies done; job rejected

Behaviour:
- Reset: state IDLE, all counters 0. Outputs reset to: we_a=0, addr_a=0, addr_valid=0, data_valid=0, data_krow=0, data_last=0, busy=0, done=0, cfg_err=0. A reset mid-job aborts it the next cycle; no done pulse.
- Start (IDLE and start=1): latch all cfg_* inputs.
  - Invalid config (W==0, H==0, C==0, or W[3:0]!=0): go to ERR. ERR lasts one cycle with done=1 and cfg_err=1, then IDLE. No beats are issued.
  - Valid config: go to RUN with busy=1.
- start is ignored outside IDLE. Config changes during a job have no effect.
- Loop nest, outermost first:
  - x = 0, 16, ..., W-16
  - r = 0 .. H-1
  - c = 0 .. C-1
  - k = 0 .. KERNEL-1
- Total beats = (W/16) * H * C * KERNEL.
- Per beat, source row s = r + k - (KERNEL-1)/2.
  - If 0 <= s < H: addr_a = base + c*plane + s*W + x, addr_valid=1.
  - Otherwise: addr_a = 0, addr_valid=0. Never drive a negative or wrapped address.
- Strides use accumulators only; no multipliers. Address arithmetic is done in ADDR_WIDTH bits.
- Issue rule (RUN): a beat issues in cycle t iff rd_ready=1.
  - The address is registered at t and presented to the DPRAM.
  - The counters advance after the issue.
- Stall (rd_ready=0): addr_a, addr_valid and all counters hold. No new beat issues.
- Read latency:
  - data_valid is asserted in the cycle dout_a is valid, i.e. one cycle after the DPRAM registers the address.
  - data_krow = k of that beat.
  - data_last = 1 on the final beat's data only.
  - Padding beats also produce data_valid; dout_a reads 0 on them.
- After the last beat issues, go to DRAIN and wait until that beat's data_valid/data_last cycle. Then go to DONE.
- DONE: one cycle, done=1, cfg_err=0. Next state IDLE; busy falls in the same cycle.
- Single-row map (H=1, KERNEL=3): every beat with k=0 or k=2 is padding.

Decomposition:
- Package dpram_seq_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE, ERR}
  - WORD_BYTES
  - localparam PAD = (KERNEL-1)/2
- Sub-module seq_loop_cnt: a generic wrap counter with inc/max/wrap outputs, instantiated four times (x, r, c, k).
- Address accumulators and the FSM stay in the top module.

Test Plan:
1. base=0x100, W=32, H=2, C=1, rd_ready=1.
   - Beats (addr_valid, addr_a): (0,0), (1,0x100), (1,0x120), (1,0x100), (1,0x120), (0,0), then the same six with +0x10.
   - 12 data_valid cycles; data_last on the 12th; done one cycle after it; busy high throughout.
2. W=16, H=3, C=2, plane=48.
   - Row 1 beats for c=1: 0x30+0, 0x30+16, 0x30+32, all addr_valid=1.
   - data_krow sequence 0,1,2 per group; 18 beats total.
3. Toggle rd_ready low for 5 cycles mid-job (W=32, H=2, C=1).
   - addr_a frozen during the stall; no data_valid during it.
   - Still exactly 12 data_valid, in the same address order as scenario 1.
4. start with W=24.
   - Next cycle done=1 and cfg_err=1, zero data_valid, back to IDLE.
   - Repeat with C=0: same response.
5. Assert rst for 1 cycle at beat 5 of scenario 1.
   - All outputs 0 next cycle, no done pulse.
   - A new start then runs the full 12 beats correctly.
6. Pulse start again while busy, and change cfg_width mid-job.
   - Both ignored; the sequence is identical to scenario 1.

Source files
------------

// File: rtl/dpram_seq_pkg.sv
// Shared types and constants for the feature-map DPRAM port-A read sequencer.
package dpram_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE,
    ERR
  } state_e;

  localparam int unsigned WORD_BYTES = 16;
  localparam int unsigned KERNEL     = 3;
  localparam int unsigned PAD        = (KERNEL - 1) / 2;

  // PAD*w built from repeated addition; PAD is an elaboration constant.
  function automatic logic [31:0] pad_span(input logic [31:0] w);
    logic [31:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < PAD; i++) begin
      acc = acc + w;
    end
    return acc;
  endfunction

endpackage

// File: rtl/dpram_rd_seq_if.sv
// Controller, DPRAM port-A and downstream-buffer signals of the read sequencer.
interface dpram_rd_seq_if #(
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned DIM_WIDTH  = 9,
  parameter int unsigned CH_WIDTH   = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] cfg_base;
  logic [DIM_WIDTH-1:0]  cfg_width;
  logic [DIM_WIDTH-1:0]  cfg_height;
  logic [CH_WIDTH-1:0]   cfg_channels;
  logic [ADDR_WIDTH-1:0] cfg_plane;
  logic                  rd_ready;
  logic                  we_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic                  addr_valid;
  logic                  data_valid;
  logic [1:0]            data_krow;
  logic                  data_last;
  logic                  busy;
  logic                  done;
  logic                  cfg_err;

  modport slave (
    input  start, cfg_base, cfg_width, cfg_height, cfg_channels, cfg_plane, rd_ready,
    output we_a, addr_a, addr_valid, data_valid, data_krow, data_last, busy, done, cfg_err
  );

  modport master (
    output start, cfg_base, cfg_width, cfg_height, cfg_channels, cfg_plane, rd_ready,
    input  we_a, addr_a, addr_valid, data_valid, data_krow, data_last, busy, done, cfg_err
  );
endinterface

// File: rtl/seq_loop_cnt.sv
// Wrap counter for one level of the loop nest: counts 0..i_max, wraps on the increment at i_max.
module seq_loop_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [WIDTH-1:0] i_max,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_wrap
);
  logic [WIDTH-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == i_max);
  assign o_cnt    = r_cnt;
  assign o_wrap   = i_inc && w_at_max;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= w_at_max ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/dpram_rd_seq.sv
// Port-A read sequencer: walks a C x H x W feature map in 3-row window order,
// one 16-byte word per beat, with padding beats above/below the map.
module dpram_rd_seq
  import dpram_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned DIM_WIDTH  = 9,
  parameter int unsigned CH_WIDTH   = 8
) (
  input logic          clk,
  input logic          rst,
  dpram_rd_seq_if.slave bus
);
  localparam int unsigned XW = DIM_WIDTH - 4;

  state_e r_state, w_next;

  logic [ADDR_WIDTH-1:0] r_plane, r_xbase, r_choff, r_rowbase, r_kwin, r_addr;
  logic [DIM_WIDTH-1:0]  r_w, r_h;
  logic [CH_WIDTH-1:0]   r_c;
  logic                  r_addr_valid, r_iss, r_iss_last, r_dv, r_dlast;
  logic [1:0]            r_iss_krow, r_dkrow;

  logic [ADDR_WIDTH-1:0] w_wext, w_pad_new, w_pad_cur;
  logic [DIM_WIDTH:0]    w_rk;
  logic                  w_accept, w_cfg_ok, w_issue, w_row_ok;
  logic                  w_busy, w_done, w_err;
  logic [1:0]            w_k;
  logic [CH_WIDTH-1:0]   w_c;
  logic [DIM_WIDTH-1:0]  w_r;
  logic [XW-1:0]         w_x;
  logic                  w_k_wrap, w_c_wrap, w_r_wrap, w_x_wrap;

  assign w_accept  = (r_state == IDLE) && bus.start;
  assign w_cfg_ok  = (|bus.cfg_width) && (|bus.cfg_height) && (|bus.cfg_channels)
                     && (bus.cfg_width[3:0] == '0);
  assign w_issue   = (r_state == RUN) && bus.rd_ready;
  assign w_wext    = ADDR_WIDTH'(r_w);
  assign w_pad_new = ADDR_WIDTH'(pad_span(32'(bus.cfg_width)));
  assign w_pad_cur = ADDR_WIDTH'(pad_span(32'(r_w)));

  // Source row s = r + k - PAD lies inside the map iff PAD <= r+k < H+PAD.
  assign w_rk     = {1'b0, w_r} + (DIM_WIDTH + 1)'(w_k);
  assign w_row_ok = (w_rk >= (DIM_WIDTH + 1)'(PAD))
                    && (w_rk < ({1'b0, r_h} + (DIM_WIDTH + 1)'(PAD)));

  seq_loop_cnt #(.WIDTH(2)) u_k_cnt (
    .clk(clk), .rst(rst), .i_clr(w_accept), .i_inc(w_issue),
    .i_max(2'(KERNEL - 1)), .o_cnt(w_k), .o_wrap(w_k_wrap)
  );
  seq_loop_cnt #(.WIDTH(CH_WIDTH)) u_c_cnt (
    .clk(clk), .rst(rst), .i_clr(w_accept), .i_inc(w_k_wrap),
    .i_max(r_c - 1'b1), .o_cnt(w_c), .o_wrap(w_c_wrap)
  );
  seq_loop_cnt #(.WIDTH(DIM_WIDTH)) u_r_cnt (
    .clk(clk), .rst(rst), .i_clr(w_accept), .i_inc(w_c_wrap),
    .i_max(r_h - 1'b1), .o_cnt(w_r), .o_wrap(w_r_wrap)
  );
  seq_loop_cnt #(.WIDTH(XW)) u_x_cnt (
    .clk(clk), .rst(rst), .i_clr(w_accept), .i_inc(w_r_wrap),
    .i_max(r_w[DIM_WIDTH-1:4] - 1'b1), .o_cnt(w_x), .o_wrap(w_x_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      IDLE:  if (bus.start) w_next = w_cfg_ok ? RUN : ERR;
      RUN: begin
        w_busy = 1'b1;
        if (w_x_wrap) w_next = DRAIN;
      end
      DRAIN: begin
        w_busy = 1'b1;
        if (r_dlast) w_next = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      ERR: begin
        w_done = 1'b1;
        w_err  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Address = x base + channel offset + s*W; the window term restarts at each
  // (r,c) group and the row base steps by W per output row.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_plane      <= '0;
      r_xbase      <= '0;
      r_choff      <= '0;
      r_rowbase    <= '0;
      r_kwin       <= '0;
      r_addr       <= '0;
      r_w          <= '0;
      r_h          <= '0;
      r_c          <= '0;
      r_addr_valid <= 1'b0;
      r_iss        <= 1'b0;
      r_iss_last   <= 1'b0;
      r_iss_krow   <= '0;
      r_dv         <= 1'b0;
      r_dlast      <= 1'b0;
      r_dkrow      <= '0;
    end else begin
      r_iss      <= w_issue;
      r_iss_krow <= w_k;
      r_iss_last <= w_x_wrap;
      r_dv       <= r_iss;
      r_dkrow    <= r_iss_krow;
      r_dlast    <= r_iss && r_iss_last;
      if (w_accept) begin
        r_w       <= bus.cfg_width;
        r_h       <= bus.cfg_height;
        r_c       <= bus.cfg_channels;
        r_plane   <= bus.cfg_plane;
        r_xbase   <= bus.cfg_base;
        r_choff   <= '0;
        r_rowbase <= '0 - w_pad_new;
        r_kwin    <= '0 - w_pad_new;
      end else if (w_issue) begin
        r_addr       <= w_row_ok ? (r_xbase + r_choff + r_kwin) : '0;
        r_addr_valid <= w_row_ok;
        if (w_k_wrap) begin
          if (w_c_wrap) begin
            r_choff <= '0;
            if (w_r_wrap) begin
              r_xbase   <= r_xbase + ADDR_WIDTH'(WORD_BYTES);
              r_rowbase <= '0 - w_pad_cur;
              r_kwin    <= '0 - w_pad_cur;
            end else begin
              r_rowbase <= r_rowbase + w_wext;
              r_kwin    <= r_rowbase + w_wext;
            end
          end else begin
            r_choff <= r_choff + r_plane;
            r_kwin  <= r_rowbase;
          end
        end else begin
          r_kwin <= r_kwin + w_wext;
        end
      end
    end
  end

  assign bus.we_a       = 1'b0;
  assign bus.addr_a     = r_addr;
  assign bus.addr_valid = r_addr_valid;
  assign bus.data_valid = r_dv;
  assign bus.data_krow  = r_dkrow;
  assign bus.data_last  = r_dlast;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.cfg_err    = w_err;

endmodule

// File: tb/tb_dpram_rd_seq.sv
// Bench for dpram_rd_seq: directed scenarios plus randomized jobs against a loop-nest model.
module tb_dpram_rd_seq;
  localparam int AW = 19;
  localparam int DW = 9;
  localparam int CW = 8;

  typedef struct packed {
    logic          av;
    logic [AW-1:0] addr;
    logic [1:0]    krow;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dpram_rd_seq_if #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW), .CH_WIDTH(CW)) bus ();

  dpram_rd_seq #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW), .CH_WIDTH(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t exp_q[$];
  beat_t obs_q[$];
  int    done_cyc, last_cyc, busy_bad, frozen_bad, dv_in_stall;
  bit    got_done, err_at_done;

  function automatic string fmt(input beat_t b);
    return $sformatf("av=%0d addr=%h krow=%0d last=%0d", b.av, b.addr, b.krow, b.last);
  endfunction

  // Expected beat stream straight from the loop nest: x, r, c, k with s = r+k-1.
  task automatic build_model(input int base, input int w, input int h, input int c, input int plane);
    exp_q.delete();
    for (int x = 0; x < w; x += 16)
      for (int r = 0; r < h; r++)
        for (int ch = 0; ch < c; ch++)
          for (int k = 0; k < 3; k++) begin
            int    s;
            beat_t b;
            s      = r + k - 1;
            b.krow = 2'(k);
            b.last = (x == w - 16) && (r == h - 1) && (ch == c - 1) && (k == 2);
            if (s >= 0 && s < h) begin
              b.av   = 1'b1;
              b.addr = AW'(base + ch * plane + s * w + x);
            end else begin
              b.av   = 1'b0;
              b.addr = '0;
            end
            exp_q.push_back(b);
          end
  endtask

  task automatic set_cfg(input int base, input int w, input int h, input int c, input int plane);
    bus.cfg_base     = AW'(base);
    bus.cfg_width    = DW'(w);
    bus.cfg_height   = DW'(h);
    bus.cfg_channels = CW'(c);
    bus.cfg_plane    = AW'(plane);
  endtask

  function automatic logic ready_for(input int mode, input int sa, input int n);
    if (mode == 1) return !(n >= sa && n < sa + 5);
    if (mode == 2) return ($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  // Pulses start at cycle 0 and records the data stream until done or budget.
  task automatic run_job(input int mode, input int sa, input bit glitch);
    logic [AW-1:0] prev_addr, stall_addr;
    logic          prev_av;
    beat_t         b;
    obs_q.delete();
    got_done = 0; err_at_done = 0; done_cyc = -1; last_cyc = -1;
    busy_bad = 0; frozen_bad = 0; dv_in_stall = 0;
    prev_addr = '0; prev_av = 1'b0; stall_addr = '0;
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.rd_ready = ready_for(mode, sa, 0);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (bus.data_valid) begin
        b.av = prev_av; b.addr = prev_addr; b.krow = bus.data_krow; b.last = bus.data_last;
        obs_q.push_back(b);
        if (!bus.busy) busy_bad++;
        if (bus.data_last) last_cyc = n;
        if (mode == 1 && n >= sa + 2 && n <= sa + 6) dv_in_stall++;
      end
      if (mode == 1 && n == sa) stall_addr = bus.addr_a;
      if (mode == 1 && n > sa && n <= sa + 5 && bus.addr_a !== stall_addr) frozen_bad++;
      prev_av   = bus.addr_valid;
      prev_addr = bus.addr_a;
      if (bus.done) begin
        got_done = 1; done_cyc = n; err_at_done = bus.cfg_err;
        break;
      end
      @(posedge clk); #1;
      bus.start = glitch && (n + 1 == 3);
      if (glitch && n + 1 == 3) bus.cfg_width = bus.cfg_width + 9'd32;
      bus.rd_ready = ready_for(mode, sa, n + 1);
    end
    bus.start    = 1'b0;
    bus.rd_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus.we_a, bus.addr_a, bus.addr_valid, bus.data_valid, bus.data_krow,
         bus.data_last, bus.busy, bus.done, bus.cfg_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: addr_a=%h av=%0d dv=%0d busy=%0d done=%0d err=%0d, all required 0",
               bus.addr_a, bus.addr_valid, bus.data_valid, bus.busy, bus.done, bus.cfg_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    set_cfg('h100, 32, 2, 1, 64);
    build_model('h100, 32, 2, 1, 64);
    run_job(0, 0, 0);
    n_tests++;
    if (!got_done) begin n_fail++; $display("FAIL basic_done: no done within budget, required done"); end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL basic_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL basic_beat%0d: got %s, required %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    n_tests++;
    if (done_cyc != last_cyc + 1 || err_at_done) begin
      n_fail++; $display("FAIL basic_done_timing: done at %0d err=%0d, required %0d err=0",
                         done_cyc, err_at_done, last_cyc + 1);
    end
    n_tests++;
    if (busy_bad != 0) begin n_fail++; $display("FAIL basic_busy: %0d data cycles without busy, required 0", busy_bad); end
  endtask

  task automatic test_multi_channel();
    set_cfg(0, 16, 3, 2, 48);
    build_model(0, 16, 3, 2, 48);
    run_job(0, 0, 0);
    n_tests++;
    if (!got_done || obs_q.size() != 18) begin
      n_fail++; $display("FAIL multi_count: got %0d beats done=%0d, required 18 done=1", obs_q.size(), got_done);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL multi_beat%0d: got %s, required %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    n_tests++;
    if (done_cyc != last_cyc + 1) begin
      n_fail++; $display("FAIL multi_done_timing: done at %0d, required %0d", done_cyc, last_cyc + 1);
    end
  endtask

  task automatic test_stall();
    set_cfg('h100, 32, 2, 1, 64);
    build_model('h100, 32, 2, 1, 64);
    run_job(1, 5, 0);
    n_tests++;
    if (!got_done || obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL stall_count: got %0d beats done=%0d, required %0d done=1",
                         obs_q.size(), got_done, exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL stall_beat%0d: got %s, required %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    n_tests++;
    if (frozen_bad != 0) begin n_fail++; $display("FAIL stall_addr_frozen: %0d address changes, required 0", frozen_bad); end
    n_tests++;
    if (dv_in_stall != 0) begin n_fail++; $display("FAIL stall_no_data: %0d data_valid in stall, required 0", dv_in_stall); end
  endtask

  task automatic test_cfg_err();
    for (int t = 0; t < 2; t++) begin
      if (t == 0) set_cfg('h100, 24, 2, 1, 48);
      else        set_cfg('h100, 32, 2, 0, 64);
      run_job(0, 0, 0);
      n_tests++;
      if (!got_done || done_cyc != 1 || !err_at_done) begin
        n_fail++; $display("FAIL cfg_err%0d_response: done at %0d err=%0d, required done at 1 err=1",
                           t, done_cyc, err_at_done);
      end
      n_tests++;
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL cfg_err%0d_beats: got %0d, required 0", t, obs_q.size()); end
      @(negedge clk);
      n_tests++;
      if (bus.busy || bus.done || bus.cfg_err) begin
        n_fail++; $display("FAIL cfg_err%0d_idle: busy=%0d done=%0d err=%0d, required 0 0 0",
                           t, bus.busy, bus.done, bus.cfg_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    int events;
    set_cfg('h100, 32, 2, 1, 64);
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.we_a, bus.addr_a, bus.addr_valid, bus.data_valid, bus.data_krow,
         bus.data_last, bus.busy, bus.done, bus.cfg_err} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: addr_a=%h av=%0d dv=%0d busy=%0d done=%0d, all required 0",
                         bus.addr_a, bus.addr_valid, bus.data_valid, bus.busy, bus.done);
    end
    events = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.data_valid || bus.busy) events++;
    end
    n_tests++;
    if (events != 0) begin n_fail++; $display("FAIL rstmid_quiet: %0d active cycles after reset, required 0", events); end
    build_model('h100, 32, 2, 1, 64);
    run_job(0, 0, 0);
    n_tests++;
    if (!got_done || obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rstmid_rerun_count: got %0d beats done=%0d, required %0d done=1",
                         obs_q.size(), got_done, exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rstmid_beat%0d: got %s, required %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_ignore_start();
    set_cfg('h100, 32, 2, 1, 64);
    build_model('h100, 32, 2, 1, 64);
    run_job(0, 0, 1);
    bus.cfg_width = 9'd32;
    n_tests++;
    if (!got_done || obs_q.size() != exp_q.size() || done_cyc != last_cyc + 1) begin
      n_fail++; $display("FAIL ignore_count: got %0d beats done at %0d, required %0d beats done at %0d",
                         obs_q.size(), done_cyc, exp_q.size(), last_cyc + 1);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL ignore_beat%0d: got %s, required %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_single_row();
    int pads;
    set_cfg('h40, 16, 1, 2, 16);
    build_model('h40, 16, 1, 2, 16);
    run_job(0, 0, 0);
    pads = 0;
    foreach (obs_q[i]) if (!obs_q[i].av) pads++;
    n_tests++;
    if (!got_done || obs_q.size() != 6 || pads != 4) begin
      n_fail++; $display("FAIL single_row_shape: got %0d beats %0d pads, required 6 beats 4 pads", obs_q.size(), pads);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL single_row_beat%0d: got %s, required %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int w, h, c, base, plane;
      w     = 16 * $urandom_range(1, 3);
      h     = $urandom_range(1, 4);
      c     = $urandom_range(1, 3);
      base  = $urandom_range(0, (1 << AW) - 1);
      plane = (it % 2 == 0) ? w * h : $urandom_range(0, 4095);
      set_cfg(base, w, h, c, plane);
      build_model(base, w, h, c, plane);
      run_job(2, 0, 0);
      n_tests++;
      if (!got_done || obs_q.size() != exp_q.size() || done_cyc != last_cyc + 1 || err_at_done) begin
        n_fail++; $display("FAIL rand%0d_job: W=%0d H=%0d C=%0d got %0d beats done=%0d@%0d, required %0d beats done@%0d",
                           it, w, h, c, obs_q.size(), got_done, done_cyc, exp_q.size(), last_cyc + 1);
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_tests++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand%0d_beat%0d: got %s, required %s", it, i, fmt(obs_q[i]), fmt(exp_q[i]));
        end
      end
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.rd_ready = 1'b1;
    set_cfg(0, 0, 0, 0, 0);
    test_reset();
    test_basic();
    test_multi_channel();
    test_stall();
    test_cfg_err();
    test_reset_mid();
    test_ignore_start();
    test_single_row();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
